adc_frame_unpacker: RTL
=======================

# adc_frame_unpacker

Sits directly downstream of the 4-lane ADC serial capture stage. It takes each completed 4×64-bit frame and splits it into eight 24-bit channel samples, checking the 8-bit header of each one. Frames are buffered in a 2-entry frame FIFO and streamed out one sample per valid/ready handshake, each tagged with channel number and frame index, to the phasor estimation pipeline.

## Interface
Parameters:
- IDX_W, 16, width of the frame index counter.
- HDR_CHECK, 1, 1 = compare header bits against the expected channel; 0 = never flag header errors.

Ports:
- MCLK  in  1  clock; all logic on rising edge.
- nRST  in  1  reset: synchronous, active-low; clock MCLK.
- DATA_READY  in  1  high while the upstream stage captures a frame; falls when DATA is updated.
- DATA  in  [63:0] x4  lane words DATA[0..3], stable from the DATA_READY falling edge until the next frame.
- SAMPLE_READY  in  1  downstream accepts a sample.
- CLR_FLAGS  in  1  synchronous clear of the sticky flags and the drop counter.
- SAMPLE_VALID  out  1  sample present on the output.
- SAMPLE_CH  out  3  channel number 0..7.
- SAMPLE_DATA  out  32  sample, sign-extended from 24 bits.
- SAMPLE_HDR_ERR  out  1  header mismatch for this sample.
- SAMPLE_IDX  out  IDX_W  frame index of this sample.
- OVERFLOW  out  1  sticky; a frame was dropped because the FIFO was full.
- HDR_ERR  out  1  sticky; any header mismatch seen.
- DROP_CNT  out  8  dropped-frame count; saturates at 255.

## Operation
- Frame detect: register dr_q <= DATA_READY. A frame event occurs in any cycle with dr_q=1 and DATA_READY=0.
- Lane layout: DATA[i] = {hdrA[7:0], smpA[23:0], hdrB[7:0], smpB[23:0]}.
  - A half is channel 2i; B half is channel 2i+1.
- Header check: hdr[7:4] must equal 4'hA, and hdr[2:0] must equal the channel number. hdr[3] is ignored. A mismatch sets that sample's error bit, and the sample is still emitted.
- Frame event, FIFO not full:
  - Push 8 samples, 8 error bits and the current frame_idx.
  - frame_idx increments, wrapping from 2^IDX_W-1 to 0.
- Frame event, FIFO full:
  - Discard the frame and set OVERFLOW.
  - DROP_CNT increments (saturating at 255).
  - frame_idx still increments, so downstream sees the gap.
- Simultaneous push and pop when full: the pop frees the entry in the same cycle, so the push is accepted and no overflow occurs.
- Serializer FSM:
  - States: IDLE, EMIT.
  - IDLE -> EMIT when the FIFO is non-empty; ch <= 0.
  - EMIT: a handshake (VALID & READY) with ch<7 gives ch++.
  - EMIT: a handshake with ch==7 pops the FIFO. The next state is EMIT with ch=0 if another frame remains after the pop, otherwise IDLE.
- Outputs in EMIT:
  - SAMPLE_VALID=1.
  - SAMPLE_CH=ch.
  - SAMPLE_DATA = sign-extended head sample[ch].
  - SAMPLE_IDX = head frame_idx.
- SAMPLE_VALID holds and SAMPLE_* stay stable until accepted; no sample is ever withdrawn.
- CLR_FLAGS clears OVERFLOW, HDR_ERR and DROP_CNT. If a set event happens in the same cycle, the set wins.

## Timing
- Reset (nRST=0 at a clock edge) sets everything to 0:
  - FSM=IDLE, FIFO empty, frame_idx=0, dr_q=0.
  - All outputs 0.
- Reset mid-stream discards buffered frames and the in-progress sample.
- Latency: frame event in cycle 0; FIFO written at the end of cycle 0; SAMPLE_VALID=1 in cycle 2 with ch 0.
- Throughput: with SAMPLE_READY held high, one sample per cycle. Back-to-back frames stream with no bubble between ch7 and the next ch0.
- A frame event in the first cycle after reset is impossible, because dr_q resets to 0.

## Structure
- Package adc_pkg holds:
  - N_LANES=4, N_CH=8, HDR_SYNC=4'hA.
  - typedef sample_t (logic signed [23:0]).
  - typedef frame_t (8 samples + 8 error bits + index).
  - enum ser_state_t {IDLE, EMIT}.
- Sub-module adc_frame_fifo: 2-entry FIFO of frame_t with 1-bit read/write pointers, a 2-bit count, and full/empty outputs. It exposes the head entry combinationally.

## Test plan
- Single frame, DATA[0]=64'hA0_7FFFFF_A1_800000, all headers correct, READY=1 -> cycles 2..9 emit ch0..7. ch0 gives SAMPLE_DATA=32'h007FFFFF, ch1 gives 32'hFF800000, IDX=0, no error flags.
- DATA[2] upper header 8'hA5 (expected channel 4) -> ch4 has SAMPLE_HDR_ERR=1 and HDR_ERR sticky=1. With HDR_CHECK=0, both stay 0.
- READY=0 while 3 frames arrive -> first two buffered, third dropped: OVERFLOW=1, DROP_CNT=1. After READY=1, 16 samples emit with IDX 0 then 1; the next frame carries IDX=3.
- FIFO full, frame event in the same cycle as the ch7 handshake -> frame accepted, OVERFLOW stays 0.
- Toggle READY randomly for 10 frames -> SAMPLE_* stable while VALID & !READY; every sample is delivered in order.
- nRST low during ch3 of a frame -> next cycle VALID=0 and FIFO empty; the next frame starts at IDX=0, ch0.

Source files
------------

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC frame unpacker
package adc_pkg;

    localparam int         N_LANES  = 4;
    localparam int         N_CH     = 8;
    localparam logic [3:0] HDR_SYNC = 4'hA;

    typedef logic signed [23:0] sample_t;

    // The frame index travels beside this struct in the FIFO, since its width
    // is a parameter of the top level.
    typedef struct packed {
        sample_t [N_CH-1:0] smp;
        logic    [N_CH-1:0] err;
    } frame_t;

    typedef enum logic {
        IDLE,
        EMIT
    } ser_state_t;

    // Bit 3 of the header is don't-care, so it is forced high on both sides.
    function automatic logic hdr_bad(input logic [7:0] hdr, input logic [2:0] ch);
        return (hdr | 8'h08) != {HDR_SYNC, 1'b1, ch};
    endfunction

endpackage

// File: rtl/adc_frame_fifo.sv
// rtl/adc_frame_fifo.sv - two-entry frame FIFO with combinational head
module adc_frame_fifo
    import adc_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic             MCLK,
    input  logic             nRST,
    input  logic             push,
    input  logic             pop,
    input  frame_t           wr_frame,
    input  logic [IDX_W-1:0] wr_idx,
    output frame_t           head_frame,
    output logic [IDX_W-1:0] head_idx,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    frame_t           mem     [2];
    logic [IDX_W-1:0] idx_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // alongside a pop is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_frame = mem[rd_ptr];
    assign head_idx   = idx_mem[rd_ptr];

    always_ff @(posedge MCLK) begin
        if (do_push) begin
            mem[wr_ptr]     <= wr_frame;
            idx_mem[wr_ptr] <= wr_idx;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_unpacker.sv
// rtl/adc_frame_unpacker.sv - splits 4x64-bit ADC frames into tagged 24-bit channel samples
module adc_frame_unpacker
    import adc_pkg::*;
#(
    parameter int IDX_W     = 16,
    parameter bit HDR_CHECK = 1'b1
) (
    input  logic             MCLK,
    input  logic             nRST,
    input  logic             DATA_READY,
    input  logic [63:0]      DATA [N_LANES],
    input  logic             SAMPLE_READY,
    input  logic             CLR_FLAGS,
    output logic             SAMPLE_VALID,
    output logic [2:0]       SAMPLE_CH,
    output logic [31:0]      SAMPLE_DATA,
    output logic             SAMPLE_HDR_ERR,
    output logic [IDX_W-1:0] SAMPLE_IDX,
    output logic             OVERFLOW,
    output logic             HDR_ERR,
    output logic [7:0]       DROP_CNT
);

    logic             dr_q;
    logic             frame_evt;
    logic [IDX_W-1:0] frame_idx;
    frame_t           in_frame;
    frame_t           head_frame;
    logic [IDX_W-1:0] head_idx;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             accept;
    logic             drop;
    ser_state_t       state, state_n;
    logic [2:0]       ch, ch_n;
    sample_t          head_smp;

    assign frame_evt = dr_q && !DATA_READY;

    always_comb begin
        in_frame = '0;
        for (int i = 0; i < N_LANES; i++) begin
            in_frame.smp[2*i]   = DATA[i][55:32];
            in_frame.smp[2*i+1] = DATA[i][23:0];
            in_frame.err[2*i]   = HDR_CHECK && hdr_bad(DATA[i][63:56], 3'(2*i));
            in_frame.err[2*i+1] = HDR_CHECK && hdr_bad(DATA[i][31:24], 3'(2*i+1));
        end
    end

    assign pop    = (state == EMIT) && SAMPLE_READY && (ch == 3'd7);
    assign accept = frame_evt && (!fifo_full || pop);
    assign drop   = frame_evt && !accept;

    adc_frame_fifo #(
        .IDX_W (IDX_W)
    ) u_fifo (
        .MCLK       (MCLK),
        .nRST       (nRST),
        .push       (frame_evt),
        .pop        (pop),
        .wr_frame   (in_frame),
        .wr_idx     (frame_idx),
        .head_frame (head_frame),
        .head_idx   (head_idx),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            state <= IDLE;
            ch    <= 3'd0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
        end
    end

    // After the ch7 pop, a frame remains if two were queued or one is being
    // pushed this very cycle; either way ch0 follows with no bubble.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = EMIT;
                    ch_n    = 3'd0;
                end
            end
            EMIT: begin
                if (SAMPLE_READY) begin
                    if (ch != 3'd7) begin
                        ch_n = ch + 3'd1;
                    end else begin
                        ch_n    = 3'd0;
                        state_n = ((fifo_count == 2'd2) || accept) ? EMIT : IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                ch_n    = 3'd0;
            end
        endcase
    end

    assign head_smp       = head_frame.smp[ch];
    assign SAMPLE_VALID   = (state == EMIT);
    assign SAMPLE_CH      = SAMPLE_VALID ? ch : 3'd0;
    assign SAMPLE_DATA    = SAMPLE_VALID ? {{8{head_smp[23]}}, head_smp} : 32'd0;
    assign SAMPLE_HDR_ERR = SAMPLE_VALID && head_frame.err[ch];
    assign SAMPLE_IDX     = SAMPLE_VALID ? head_idx : '0;

    // Dropped frames still consume an index so downstream can see the gap.
    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            dr_q      <= 1'b0;
            frame_idx <= '0;
            OVERFLOW  <= 1'b0;
            HDR_ERR   <= 1'b0;
            DROP_CNT  <= 8'd0;
        end else begin
            dr_q <= DATA_READY;
            if (frame_evt) frame_idx <= frame_idx + IDX_W'(1);

            if (drop)           OVERFLOW <= 1'b1;
            else if (CLR_FLAGS) OVERFLOW <= 1'b0;

            if (accept && (|in_frame.err)) HDR_ERR <= 1'b1;
            else if (CLR_FLAGS)            HDR_ERR <= 1'b0;

            if (drop) begin
                if (CLR_FLAGS)               DROP_CNT <= 8'd1;
                else if (DROP_CNT != 8'hFF)  DROP_CNT <= DROP_CNT + 8'd1;
            end else if (CLR_FLAGS) begin
                DROP_CNT <= 8'd0;
            end
        end
    end

endmodule
